// File: rtl/drr_scheduler_if.sv
// Grant handshake and per-queue head-of-line status between the packet-size
// sources, the DRR scheduler and the egress consumer.
interface drr_scheduler_if #(
   parameter int PKT_QS_CNT = 4
) ();
   localparam int ADDR_W = $clog2(PKT_QS_CNT);

   logic [PKT_QS_CNT-1:0][15:0] size_i;
   logic [PKT_QS_CNT-1:0]       size_val_i;
   logic                        pkt_ready_i;
   logic                        pkt_val_o;
   logic [ADDR_W-1:0]           pkt_addr_o;
   logic [15:0]                 pkt_size_o;

   modport slave (
      input  size_i, size_val_i, pkt_ready_i,
      output pkt_val_o, pkt_addr_o, pkt_size_o
   );

   modport master (
      output size_i, size_val_i, pkt_ready_i,
      input  pkt_val_o, pkt_addr_o, pkt_size_o
   );
endinterface

// File: rtl/drr_scheduler.sv
// Deficit-round-robin scheduler: visits queues in order, credits one quantum
// per visit and grants head packets while they fit in the queue's deficit.
//
// state  | meaning
// SCAN   | look at queue ptr; empty queues lose their deficit and are skipped
// CREDIT | add QUANTUM to deficit[ptr], saturating
// CHECK  | grant head packet if it fits, else move on (clear if queue empty)
// SEND   | grant held on the bus until the consumer accepts it
module drr_scheduler #(
   parameter int PKT_QS_CNT = 4,
   parameter int QUANTUM    = 500,
   parameter int DEFICIT_W  = 17
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   drr_scheduler_if.slave         pkt_if,
   output logic                   busy_o
);
   localparam int PTR_W = $clog2(PKT_QS_CNT);
   localparam logic [DEFICIT_W-1:0] DEF_MAX = '1;

   typedef enum logic [1:0] {SCAN, CREDIT, CHECK, SEND} state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_nxt;
   logic [DEFICIT_W-1:0]   deficit_q [PKT_QS_CNT];
   logic [DEFICIT_W-1:0]   deficit_d [PKT_QS_CNT];
   logic                   pkt_val_q, pkt_val_d;
   logic [PTR_W-1:0]       pkt_addr_q, pkt_addr_d;
   logic [15:0]            pkt_size_q, pkt_size_d;

   logic                   head_val;
   logic [15:0]            head_size;
   logic [DEFICIT_W-1:0]   cur_def;
   logic [DEFICIT_W:0]     credit_sum;
   logic                   fits;
   logic                   xfer;

   assign head_val   = pkt_if.size_val_i[ptr_q];
   assign head_size  = pkt_if.size_i[ptr_q];
   assign cur_def    = deficit_q[ptr_q];
   assign credit_sum = {1'b0, cur_def} + (DEFICIT_W+1)'(QUANTUM);
   assign fits       = {{(DEFICIT_W-16){1'b0}}, head_size} <= cur_def;
   assign xfer       = pkt_val_q & pkt_if.pkt_ready_i;
   assign ptr_nxt    = (ptr_q == PTR_W'(PKT_QS_CNT-1)) ? '0 : ptr_q + PTR_W'(1);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= SCAN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:    if (head_val) state_d = CREDIT;
         CREDIT:  state_d = CHECK;
         CHECK:   state_d = (head_val && fits) ? SEND : SCAN;
         SEND:    if (xfer) state_d = CHECK;
         default: state_d = SCAN;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      deficit_d  = deficit_q;
      pkt_val_d  = pkt_val_q;
      pkt_addr_d = pkt_addr_q;
      pkt_size_d = pkt_size_q;
      case (state_q)
         SCAN: begin
            if (!head_val) begin
               deficit_d[ptr_q] = '0;
               ptr_d            = ptr_nxt;
            end
         end
         CREDIT: begin
            deficit_d[ptr_q] = credit_sum[DEFICIT_W] ? DEF_MAX : credit_sum[DEFICIT_W-1:0];
         end
         CHECK: begin
            if (!head_val) begin
               deficit_d[ptr_q] = '0;
               ptr_d            = ptr_nxt;
            end else if (fits) begin
               pkt_val_d  = 1'b1;
               pkt_addr_d = ptr_q;
               pkt_size_d = head_size;
            end else begin
               ptr_d = ptr_nxt;
            end
         end
         SEND: begin
            // Cannot underflow: the grant was only issued with size <= deficit.
            if (xfer) begin
               pkt_val_d        = 1'b0;
               deficit_d[ptr_q] = cur_def - {{(DEFICIT_W-16){1'b0}}, pkt_size_q};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ptr_q      <= '0;
         pkt_val_q  <= 1'b0;
         pkt_addr_q <= '0;
         pkt_size_q <= '0;
         for (int i = 0; i < PKT_QS_CNT; i++) deficit_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         pkt_val_q  <= pkt_val_d;
         pkt_addr_q <= pkt_addr_d;
         pkt_size_q <= pkt_size_d;
         deficit_q  <= deficit_d;
      end
   end

   assign pkt_if.pkt_val_o  = pkt_val_q;
   assign pkt_if.pkt_addr_o = pkt_addr_q;
   assign pkt_if.pkt_size_o = pkt_size_q;
   assign busy_o            = (state_q != SCAN);
endmodule

// File: tb/tb_drr_scheduler.sv
// Directed bench for drr_scheduler: reset, grant latency, fixed-size rounds,
// backpressure, idle-queue clearing, wrap/skip and a random run against a DRR model.
module tb_drr_scheduler;
   localparam int N = 4;
   localparam int Q = 500;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic busy;

   drr_scheduler_if #(.PKT_QS_CNT(N)) pif ();

   drr_scheduler #(.PKT_QS_CNT(N), .QUANTUM(Q), .DEFICIT_W(17)) dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .pkt_if (pif),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int pkts [N][$];
   int got_a [$];
   int got_s [$];
   int exp_a [$];
   int exp_s [$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic reset_apply();
      @(negedge clk);
      rst_n           = 1'b0;
      pif.size_val_i  = '0;
      pif.size_i      = '0;
      pif.pkt_ready_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_grant(input string tag);
      int k = 0;
      while (!pif.pkt_val_o && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, int'(pif.pkt_val_o), 1);
   endtask

   task automatic present(input int a);
      if (pkts[a].size() > 0) begin
         pif.size_i[a]     = 16'(pkts[a][0]);
         pif.size_val_i[a] = 1'b1;
      end else begin
         pif.size_i[a]     = '0;
         pif.size_val_i[a] = 1'b0;
      end
   endtask

   task automatic collect(input int n, input bit pop, input bit rnd);
      int cyc = 0;
      bit xf;
      int a, s;
      got_a.delete();
      got_s.delete();
      while (got_a.size() < n && cyc < 20000) begin
         @(negedge clk);
         xf = pif.pkt_val_o && pif.pkt_ready_i;
         a  = int'(pif.pkt_addr_o);
         s  = int'(pif.pkt_size_o);
         @(posedge clk); #1;
         cyc++;
         if (xf) begin
            got_a.push_back(a);
            got_s.push_back(s);
            if (pop && pkts[a].size() > 0) begin
               void'(pkts[a].pop_front());
               present(a);
            end
         end
         if (rnd) pif.pkt_ready_i = 1'($urandom_range(0, 1));
      end
      check("collect_count", got_a.size(), n);
   endtask

   // Grant-level DRR reference: whole visits, not cycles.
   task automatic build_model();
      int m [N][$];
      int def [N];
      int p = 0;
      int left = 0;
      exp_a.delete();
      exp_s.delete();
      for (int i = 0; i < N; i++) begin
         m[i]   = pkts[i];
         def[i] = 0;
         left  += pkts[i].size();
      end
      while (left > 0) begin
         if (m[p].size() == 0) begin
            def[p] = 0;
         end else begin
            def[p] += Q;
            if (def[p] > 131071) def[p] = 131071;
            while (m[p].size() > 0 && m[p][0] <= def[p]) begin
               exp_a.push_back(p);
               exp_s.push_back(m[p][0]);
               def[p] -= m[p][0];
               void'(m[p].pop_front());
               left--;
            end
            if (m[p].size() == 0) def[p] = 0;
         end
         p = (p + 1) % N;
      end
   endtask

   initial begin
      int hc_exp [24] = '{0,0,2,2, 0,0,0,1,2,2,2, 0,0,1,2,2, 0,0,0,1,2,2,2,3};
      int hs [N]      = '{200, 600, 200, 1800};
      int n_edge, rises, wrap_seen, prev_ptr;
      bit prev_busy;

      pif.size_i      = '0;
      pif.size_val_i  = '0;
      pif.pkt_ready_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_val",  int'(pif.pkt_val_o), 0);
      check("rst_addr", int'(pif.pkt_addr_o), 0);
      check("rst_size", int'(pif.pkt_size_o), 0);
      check("rst_busy", int'(busy), 0);

      // First grant three edges after q0 becomes valid at ptr=0.
      @(negedge clk);
      pif.size_i[0]     = 16'd300;
      pif.size_val_i[0] = 1'b1;
      rst_n             = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #1;
         check($sformatf("lat_val_e%0d", e), int'(pif.pkt_val_o), (e == 3) ? 1 : 0);
         if (e == 1) check("lat_busy", int'(busy), 1);
      end
      check("lat_addr", int'(pif.pkt_addr_o), 0);
      check("lat_size", int'(pif.pkt_size_o), 300);

      // Asynchronous reset in SEND with no ready.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_val",  int'(pif.pkt_val_o), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_def0", int'(dut.deficit_q[0]), 0);

      // Fixed sizes, ready always high.
      reset_apply();
      for (int i = 0; i < N; i++) pif.size_i[i] = 16'(hs[i]);
      pif.size_val_i  = '1;
      pif.pkt_ready_i = 1'b1;
      rst_n           = 1'b1;
      collect(24, 1'b0, 1'b0);
      for (int i = 0; i < 24 && i < got_a.size(); i++) begin
         check($sformatf("hc_addr%0d", i), got_a[i], hc_exp[i]);
         check($sformatf("hc_size%0d", i), got_s[i], hs[hc_exp[i]]);
      end

      // Backpressure: grant must stay frozen while sources change.
      reset_apply();
      pif.size_i[0]     = 16'd300;
      pif.size_val_i[0] = 1'b1;
      rst_n             = 1'b1;
      wait_grant("bp_grant");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         pif.size_i[0]     = 16'($urandom_range(0, 65535));
         pif.size_val_i[0] = 1'b0;
         @(posedge clk); #1;
         check($sformatf("bp_val%0d", c),  int'(pif.pkt_val_o), 1);
         check($sformatf("bp_addr%0d", c), int'(pif.pkt_addr_o), 0);
         check($sformatf("bp_size%0d", c), int'(pif.pkt_size_o), 300);
      end
      @(negedge clk);
      pif.size_i[0]     = 16'd300;
      pif.size_val_i[0] = 1'b1;
      pif.pkt_ready_i   = 1'b1;
      @(posedge clk); #1;
      pif.pkt_ready_i = 1'b0;
      check("bp_drop",    int'(pif.pkt_val_o), 0);
      check("bp_deficit", int'(dut.deficit_q[0]), 200);
      @(posedge clk); #1;
      check("bp_noregrant", int'(pif.pkt_val_o), 0);

      // Leftover deficit is cleared when the queue is found empty.
      reset_apply();
      pif.size_i[1]     = 16'd100;
      pif.size_val_i[1] = 1'b1;
      pif.pkt_ready_i   = 1'b1;
      rst_n             = 1'b1;
      wait_grant("clr_grant");
      check("clr_addr", int'(pif.pkt_addr_o), 1);
      @(posedge clk); #1;
      pif.size_i[1] = 16'd600;
      @(posedge clk); #1;
      check("clr_noval",    int'(pif.pkt_val_o), 0);
      check("clr_leftover", int'(dut.deficit_q[1]), 400);
      pif.size_val_i[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("clr_zero", int'(dut.deficit_q[1]), 0);
      pif.size_val_i[1] = 1'b1;
      n_edge = 0;
      while (!busy && n_edge < 20) begin
         @(posedge clk); #1;
         n_edge++;
      end
      check("clr_credit_seen", int'(busy), 1);
      @(posedge clk); #1;
      check("clr_one_quantum", int'(dut.deficit_q[1]), 500);
      @(posedge clk); #1;
      check("clr_no_early", int'(pif.pkt_val_o), 0);
      wait_grant("clr_regrant");
      check("clr_resize", int'(pif.pkt_size_o), 600);

      // Wrap and skip: lone q3 of 1500 is granted on its third visit.
      reset_apply();
      pif.size_i[3]     = 16'd1500;
      pif.size_val_i[3] = 1'b1;
      rst_n             = 1'b1;
      n_edge = 0; rises = 0; wrap_seen = 0; prev_ptr = 0; prev_busy = 1'b0;
      while (!pif.pkt_val_o && n_edge < 40) begin
         @(posedge clk); #1;
         n_edge++;
         if (prev_ptr == 3 && int'(dut.ptr_q) == 0) wrap_seen = 1;
         if (busy && !prev_busy) rises++;
         prev_ptr  = int'(dut.ptr_q);
         prev_busy = busy;
      end
      check("wrap_latency", n_edge, 18);
      check("wrap_visits",  rises, 3);
      check("wrap_seen",    wrap_seen, 1);
      check("wrap_addr",    int'(pif.pkt_addr_o), 3);
      check("wrap_size",    int'(pif.pkt_size_o), 1500);

      // Random sizes, source pops on transfer, random ready.
      reset_apply();
      for (int i = 0; i < N; i++) begin
         pkts[i].delete();
         for (int j = 0; j < 6; j++) pkts[i].push_back($urandom_range(64, 1500));
      end
      build_model();
      for (int i = 0; i < N; i++) present(i);
      pif.pkt_ready_i = 1'($urandom_range(0, 1));
      rst_n           = 1'b1;
      collect(exp_a.size(), 1'b1, 1'b1);
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         check($sformatf("rnd_addr%0d", i), got_a[i], exp_a[i]);
         check($sformatf("rnd_size%0d", i), got_s[i], exp_s[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/drr_scheduler.md
# drr_scheduler

Deficit-round-robin packet scheduler for PKT_QS_CNT input queues. It reads each queue's head-of-line packet size and valid flag and grants one packet at a time to the downstream consumer over a valid/ready handshake. Each accepted grant is the dequeue command back to the queue source: `pkt_addr_o` and `pkt_val_o && pkt_ready_i` drive the source's change address and change-valid inputs. It sits between the per-queue packet-size sources and the shared egress datapath.

## Interface

- PKT_QS_CNT, 4, number of queues, ≥2.
- QUANTUM, 500, bytes credited per visit, 1..65535.
- DEFICIT_W, 17, deficit counter width, fixed; covers QUANTUM + max leftover.
- clk_i, input, 1, single clock, rising edge.
- rst_i, input, 1, reset, asynchronous, active-low.
- size_i, input, [PKT_QS_CNT-1:0][15:0], head-of-line packet size per queue, bytes.
- size_val_i, input, [PKT_QS_CNT-1:0], queue i has a head packet.
- pkt_ready_i, input, 1, downstream accepts the grant.
- pkt_val_o, output, 1, grant valid.
- pkt_addr_o, output, $clog2(PKT_QS_CNT), granted queue index.
- pkt_size_o, output, 16, granted packet size, latched.
- busy_o, output, 1, FSM not in SCAN.

## Operation

- Registered state: `ptr` (current queue), `deficit[i]` (DEFICIT_W bits each), FSM, and all outputs.
- FSM states:
  - SCAN:
    - size_val_i[ptr]=1 → CREDIT.
    - Else deficit[ptr]←0, ptr←ptr+1 (wraps PKT_QS_CNT-1→0), stay SCAN.
  - CREDIT: deficit[ptr]←deficit[ptr]+QUANTUM, saturating at 2^DEFICIT_W−1 → CHECK.
  - CHECK:
    - size_val_i[ptr]=0 → deficit[ptr]←0, advance ptr → SCAN.
    - Else size_i[ptr] ≤ deficit[ptr] → pkt_val_o←1, pkt_addr_o←ptr, pkt_size_o←size_i[ptr] → SEND.
    - Else (size exceeds deficit) → deficit retained, advance ptr → SCAN.
  - SEND:
    - Outputs held stable.
    - On pkt_val_o && pkt_ready_i: pkt_val_o←0, deficit[ptr]←deficit[ptr]−pkt_size_o → CHECK.
- Comparison and subtraction are unsigned.
  - The subtraction cannot underflow, because a grant only happens when size ≤ deficit.
  - Size 0 is eligible and subtracts 0.
- size_i and size_val_i changes during SEND are ignored. A committed grant always completes.
- The deficit of an idle queue is cleared on every visit to it (in SCAN or CHECK). No credit carries over once a queue is empty.
- One CREDIT per visit. Back-to-back grants from the same queue reuse the remaining deficit.

## Timing

- Reset (rst_i=0, asynchronous): pkt_val_o=0, pkt_addr_o=0, pkt_size_o=0, busy_o=0, ptr=0, all deficits 0, FSM=SCAN. Outputs change immediately, without waiting for a clock. Reset asserted during SEND drops the grant with no deficit update.
- First grant: queue valid at ptr while in SCAN at cycle 0 → CREDIT at cycle 1 → CHECK at cycle 2 → pkt_val_o high from cycle 3.
- Empty queue: SCAN skips it in 1 cycle.
- Ineligible queue: CREDIT+CHECK skip it in 2 cycles, plus 1 SCAN cycle.
- Handshake:
  - Transfer occurs on the rising edge where pkt_val_o=1 and pkt_ready_i=1.
  - pkt_val_o deasserts the next cycle. Grants are never back-to-back on consecutive cycles.
  - pkt_ready_i may be high before pkt_val_o. A transfer still takes ≥1 cycle of pkt_val_o.
- After a transfer at edge N, CHECK evaluates at cycle N+1. The source must present the updated size_i/size_val_i by then (one cycle after its change-valid). The next grant from the same queue is visible at N+2.
- All queues empty: FSM circulates in SCAN, 1 queue per cycle. busy_o=0 throughout; pkt_val_o=0.

## Test plan

- Reset:
  - Drive rst_i=0 mid-SEND with pkt_ready_i=0.
  - Require pkt_val_o=0 asynchronously (before the next edge) and busy_o=0.
  - After release with all queues empty, require the first grant 3 cycles after a queue becomes valid at ptr=0.
- Hardcoded sizes:
  - QUANTUM=500, sizes {200,600,200,1800}, all valid and held constant, pkt_ready_i=1.
  - Round 1 grant sequence: q0,q0,q2,q2.
  - Round 2 (deficits q0=600, q1=1000, q2=600, q3=1000): q0×3, q1, q2×3.
  - q3 is first granted in round 4 (deficit 2000).
- Backpressure:
  - Hold pkt_ready_i=0 for 10 cycles during SEND while changing size_i[addr] and dropping size_val_i.
  - Require pkt_addr_o and pkt_size_o stable and pkt_val_o=1 throughout.
  - On ready, require exactly one transfer and the deficit reduced by the latched size.
- Empty-queue clear:
  - q1 has leftover deficit 400, then size_val_i[1] drops.
  - On the next visit, require deficit[1]=0. When q1 becomes valid again it gets exactly one QUANTUM.
- Wrap and skip:
  - Only q3 valid, size 1500, QUANTUM=500.
  - Require ptr wrap 3→0 and a grant on the third visit to q3.
  - No grants for q0–q2.
- Random vs model:
  - Sizes 64..1500, source updates size one cycle after the transfer, random pkt_ready_i.
  - Require grant order to match a reference DRR model, and no grant with size > deficit.
